// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA sync generator and the receive monitor,
// so both ends of the link are built from one set of numbers.
package vga_timing_pkg;

    localparam int   H_DISPLAY = 640;
    localparam int   H_FRONT   = 16;
    localparam int   H_SYNC    = 96;
    localparam int   H_BACK    = 48;
    localparam int   H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int   V_DISPLAY = 480;
    localparam int   V_FRONT   = 10;
    localparam int   V_SYNC    = 2;
    localparam int   V_BACK    = 33;
    localparam int   V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic SYNC_POL  = 1'b1;

    // Modulo counter step: returns 0 after reaching the last value.
    function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
        wrap_inc = (val == last) ? 10'd0 : val + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Leading-edge detector for one sync line; the history register only moves on the pixel
// strobe so the edge is measured in pixel time, not clk time.
module sync_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync,
    output logic lead
);

    logic prev_r;

    // Previous sync level as seen on the last pixel strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= ~POL;
        end else if (pix_en) begin
            prev_r <= sync;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign lead = pix_en && (sync == POL) && (prev_r != POL);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: locks a pixel counter to incoming sync edges, checks the timing,
// and reports a per-frame active-pixel checksum plus a single-pixel probe capture.
module vga_rx_monitor
    import vga_timing_pkg::*;
#(
    parameter int   H_ACT    = H_DISPLAY,
    parameter int   H_FP     = H_FRONT,
    parameter int   H_SW     = H_SYNC,
    parameter int   H_BP     = H_BACK,
    parameter int   V_ACT    = V_DISPLAY,
    parameter int   V_FP     = V_FRONT,
    parameter int   V_SW     = V_SYNC,
    parameter int   V_BP     = V_BACK,
    parameter logic SYNC_LVL = SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic [7:0]  err_cnt,
    output logic [31:0] frame_sum,
    output logic        frame_done,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
);

    localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
    localparam logic [9:0] H_EDGE_W = 10'(H_ACT + H_FP);
    localparam logic [9:0] V_EDGE_W = 10'(V_ACT + V_FP);
    localparam logic [9:0] H_LAST_W = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_LAST_W = 10'(V_ACT + V_FP + V_SW + V_BP - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [9:0]    cx_r, cy_r;
    logic [9:0]    cur_x_s, cur_y_s, nx_s, ny_s;
    logic          h_lead_s, v_lead_s;
    logic          mismatch_s, active_s, wrap_s, hit_s;
    logic [31:0]   acc_r, acc_s, sum_s;
    logic          ok_r, ok_s;
    logic [7:0]    err_s;
    logic          done_s, pval_s;
    logic [11:0]   prgb_s;

    sync_edge_det #(.POL(SYNC_LVL)) u_hs_edge (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sync(hsync), .lead(h_lead_s)
    );

    sync_edge_det #(.POL(SYNC_LVL)) u_vs_edge (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sync(vsync), .lead(v_lead_s)
    );

    // Position of the sample on the inputs (re-anchored by a vsync edge while searching) and its successor
    always_comb begin
        if ((state_r == ST_SEARCH) && v_lead_s) begin
            cur_x_s = 10'd0;
            cur_y_s = V_EDGE_W;
        end else begin
            cur_x_s = cx_r;
            cur_y_s = cy_r;
        end
        if (pix_en) begin
            nx_s = wrap_inc(cur_x_s, H_LAST_W);
            if (cur_x_s == H_LAST_W) begin
                ny_s = wrap_inc(cur_y_s, V_LAST_W);
            end else begin
                ny_s = cur_y_s;
            end
        end else begin
            nx_s = cx_r;
            ny_s = cy_r;
        end
    end

    // An edge where none is due, or no edge where one is due, both count as a mismatch.
    assign mismatch_s = (h_lead_s != (cur_x_s == H_EDGE_W)) ||
                        (v_lead_s != ((cur_x_s == 10'd0) && (cur_y_s == V_EDGE_W)));
    assign active_s   = (cur_x_s < H_ACT_W) && (cur_y_s < V_ACT_W);
    assign wrap_s     = (cur_x_s == H_LAST_W) && (cur_y_s == V_LAST_W);
    assign hit_s      = active_s && (cur_x_s == probe_x) && (cur_y_s == probe_y);

    // Lock FSM next state plus checksum, error and probe bookkeeping for one pixel sample
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        ok_s    = ok_r;
        err_s   = err_cnt;
        sum_s   = frame_sum;
        done_s  = 1'b0;
        prgb_s  = probe_rgb;
        pval_s  = 1'b0;
        if (pix_en) begin
            case (state_r)
                ST_SEARCH: begin
                    if (v_lead_s) begin
                        state_s = ST_TRAIN;
                    end else begin
                        state_s = ST_SEARCH;
                    end
                end
                ST_TRAIN: begin
                    if (mismatch_s) begin
                        state_s = ST_SEARCH;
                    end else if (v_lead_s) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_TRAIN;
                    end
                end
                ST_LOCKED: begin
                    if (mismatch_s) begin
                        // Losing lock outranks any checksum or probe work on this sample.
                        state_s = ST_SEARCH;
                        ok_s    = 1'b0;
                        err_s   = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
                    end else begin
                        if (active_s) begin
                            acc_s = acc_r + {20'd0, rgb};
                        end else begin
                            acc_s = acc_r;
                        end
                        if (hit_s) begin
                            prgb_s = rgb;
                            pval_s = 1'b1;
                        end else begin
                            pval_s = 1'b0;
                        end
                        if (wrap_s) begin
                            if (ok_r) begin
                                sum_s  = acc_s;
                                done_s = 1'b1;
                            end else begin
                                sum_s  = frame_sum;
                            end
                            acc_s = 32'd0;
                            ok_s  = 1'b1;
                        end else begin
                            ok_s  = ok_r;
                        end
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SEARCH;
            cx_r        <= 10'd0;
            cy_r        <= 10'd0;
            acc_r       <= 32'd0;
            ok_r        <= 1'b0;
            de          <= 1'b0;
            locked      <= 1'b0;
            err_cnt     <= 8'd0;
            frame_sum   <= 32'd0;
            frame_done  <= 1'b0;
            probe_rgb   <= 12'd0;
            probe_valid <= 1'b0;
        end else begin
            state_r     <= state_s;
            cx_r        <= nx_s;
            cy_r        <= ny_s;
            acc_r       <= acc_s;
            ok_r        <= ok_s;
            de          <= (state_s == ST_LOCKED) && (nx_s < H_ACT_W) && (ny_s < V_ACT_W);
            locked      <= (state_s == ST_LOCKED);
            err_cnt     <= err_s;
            frame_sum   <= sum_s;
            frame_done  <= done_s;
            probe_rgb   <= prgb_s;
            probe_valid <= pval_s;
        end
    end

    assign x = cx_r;
    assign y = cy_r;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a scaled-down raster: a stream generator, an arithmetic
// reference model driven by sample index, and a phase table of stream scenarios.
module tb_vga_rx_monitor;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int HE = HA + HF;
    localparam int VE = VA + VF;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync;
    logic [11:0] rgb;
    logic [9:0]  probe_x, probe_y;
    logic [9:0]  x, y;
    logic        de, locked, frame_done, probe_valid;
    logic [7:0]  err_cnt;
    logic [31:0] frame_sum;
    logic [11:0] probe_rgb;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_ACT(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB), .SYNC_LVL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .x(x), .y(y), .de(de),
        .locked(locked), .err_cnt(err_cnt), .frame_sum(frame_sum),
        .frame_done(frame_done), .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: position is plain arithmetic on the sample index from an anchor.
    int          m_mode;      // 0 hunting, 1 verifying, 2 locked
    longint      m_n, m_a;
    int          m_ay;
    bit          m_hp, m_vp, m_ok, m_done, m_pv;
    int          m_err;
    logic [31:0] m_acc, m_sum;
    logic [11:0] m_prgb;

    function automatic int pos(input longint n);
        return int'((longint'(m_ay) * HT + (n - m_a)) % FR);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_a = m_n; m_ay = 0; m_hp = 0; m_vp = 0; m_ok = 0;
        m_err = 0; m_acc = 0; m_sum = 0; m_prgb = 0; m_done = 0; m_pv = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic [11:0] c);
        int lin, px, py;
        bit hl, vl, bad, act;
        lin = pos(m_n);
        px = lin % HT;
        py = lin / HT;
        hl = hs && !m_hp;
        vl = vs && !m_vp;
        m_hp = hs;
        m_vp = vs;
        m_done = 0;
        m_pv = 0;
        bad = (hl != (px == HE)) || (vl != (lin == VE * HT));
        act = (px < HA) && (py < VA);
        if (m_mode == 0) begin
            if (vl) begin m_a = m_n; m_ay = VE; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (bad) m_mode = 0;
            else if (vl) m_mode = 2;
        end else begin
            if (bad) begin
                m_mode = 0; m_ok = 0;
                if (m_err < 255) m_err++;
            end else begin
                if (act) m_acc = m_acc + {20'd0, c};
                if (act && px == int'(probe_x) && py == int'(probe_y)) begin
                    m_prgb = c; m_pv = 1;
                end
                if (lin == FR - 1) begin
                    if (m_ok) begin m_sum = m_acc; m_done = 1; end
                    m_acc = 0; m_ok = 1;
                end
            end
        end
        m_n++;
    endtask

    task automatic check_outputs(input bit after_strobe);
        int lin, ex, ey;
        bit el;
        lin = pos(m_n);
        ex = lin % HT;
        ey = lin / HT;
        el = (m_mode == 2);
        chk("x", x, ex);
        chk("y", y, ey);
        chk("locked", locked, el);
        chk("de", de, el && ex < HA && ey < VA);
        chk("err_cnt", err_cnt, m_err);
        chk("frame_sum", frame_sum, m_sum);
        chk("probe_rgb", probe_rgb, m_prgb);
        chk("frame_done", frame_done, after_strobe && m_done);
        chk("probe_valid", probe_valid, after_strobe && m_pv);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_sum"}, frame_sum, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_prgb"}, probe_rgb, 0);
        chk({tag, "_pv"}, probe_valid, 0);
    endtask

    int ph_done, ph_pv;

    task automatic strobe(input logic hs, input logic vs, input logic [11:0] c);
        @(negedge clk);
        pix_en = 1'b1; hsync = hs; vsync = vs; rgb = c;
        model_step(hs, vs, c);
        @(negedge clk);
        pix_en = 1'b0;
        hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom);
        check_outputs(1'b1);
        ph_done += int'(frame_done);
        ph_pv += int'(probe_valid);
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
        chk("probe_valid_width", probe_valid, 0);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("midrst");
        model_reset();
    endtask

    task automatic stall(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom);
            check_outputs(1'b0);
        end
    endtask

    typedef struct {
        int          frames;
        int          stretch_line;
        int          rst_x, rst_y;
        int          stall_x, stall_y;
        logic [9:0]  px, py;
        bit          rnd;
        logic [11:0] cval;
        bit          paint;
        logic [11:0] paint_val;
        int          exp_done, exp_pv;
        bit          exp_locked;
        int          exp_err;
        bit          chk_sum;
        logic [31:0] exp_sum;
        logic [11:0] exp_prgb;
    } phase_t;

    phase_t phases[5];

    task automatic run_phase(input int idx, input phase_t p);
        int len;
        logic [11:0] c;
        probe_x = p.px;
        probe_y = p.py;
        ph_done = 0;
        ph_pv = 0;
        for (int f = 0; f < p.frames; f++) begin
            for (int v = 0; v < VT; v++) begin
                len = (f == 0 && v == p.stretch_line) ? HT + 1 : HT;
                for (int h = 0; h < len; h++) begin
                    if (f == 0 && h == p.rst_x && v == p.rst_y) mid_reset();
                    if (f == 0 && h == p.stall_x && v == p.stall_y) stall(1000);
                    if (h < HA && v < VA) begin
                        if (p.paint && h == int'(p.px) && v == int'(p.py)) c = p.paint_val;
                        else if (p.rnd) c = 12'($urandom);
                        else c = p.cval;
                    end else begin
                        c = 12'($urandom);
                    end
                    strobe(h >= HE && h < HE + HS, v >= VE && v < VE + VS, c);
                end
            end
        end
        chk($sformatf("phase%0d_frame_done_count", idx), ph_done, p.exp_done);
        chk($sformatf("phase%0d_probe_valid_count", idx), ph_pv, p.exp_pv);
        chk($sformatf("phase%0d_locked", idx), locked, p.exp_locked);
        chk($sformatf("phase%0d_err_cnt", idx), err_cnt, p.exp_err);
        chk($sformatf("phase%0d_probe_rgb", idx), probe_rgb, p.exp_prgb);
        if (p.chk_sum) chk($sformatf("phase%0d_frame_sum", idx), frame_sum, p.exp_sum);
    endtask

    initial begin
        // Constant 12'h0ff over the 16x12 active area: 255 * 192 = 48960.
        phases[0] = '{frames:4, stretch_line:-1, rst_x:-1, rst_y:-1, stall_x:-1, stall_y:-1,
                      px:10'd20, py:10'd3, rnd:0, cval:12'h0ff, paint:0, paint_val:12'h000,
                      exp_done:2, exp_pv:0, exp_locked:1, exp_err:0, chk_sum:1,
                      exp_sum:32'h0000BF40, exp_prgb:12'h000};
        phases[1] = '{frames:2, stretch_line:-1, rst_x:-1, rst_y:-1, stall_x:-1, stall_y:-1,
                      px:10'd8, py:10'd6, rnd:1, cval:12'h000, paint:1, paint_val:12'hf99,
                      exp_done:2, exp_pv:2, exp_locked:1, exp_err:0, chk_sum:0,
                      exp_sum:32'h0, exp_prgb:12'hf99};
        phases[2] = '{frames:3, stretch_line:3, rst_x:-1, rst_y:-1, stall_x:-1, stall_y:-1,
                      px:10'd3, py:10'd15, rnd:0, cval:12'h0ff, paint:0, paint_val:12'h000,
                      exp_done:1, exp_pv:0, exp_locked:1, exp_err:1, chk_sum:1,
                      exp_sum:32'h0000BF40, exp_prgb:12'hf99};
        phases[3] = '{frames:3, stretch_line:-1, rst_x:10, rst_y:5, stall_x:-1, stall_y:-1,
                      px:10'd20, py:10'd3, rnd:0, cval:12'h0ff, paint:0, paint_val:12'h000,
                      exp_done:1, exp_pv:0, exp_locked:1, exp_err:0, chk_sum:1,
                      exp_sum:32'h0000BF40, exp_prgb:12'h000};
        phases[4] = '{frames:2, stretch_line:-1, rst_x:-1, rst_y:-1, stall_x:5, stall_y:7,
                      px:10'd20, py:10'd3, rnd:1, cval:12'h000, paint:0, paint_val:12'h000,
                      exp_done:2, exp_pv:0, exp_locked:1, exp_err:0, chk_sum:0,
                      exp_sum:32'h0, exp_prgb:12'h000};

        reset = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 12'h000;
        probe_x = 10'd0; probe_y = 10'd0;
        m_n = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 5; i++) run_phase(i, phases[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side counterpart of the VGA sync generator. Consumes the hsync/vsync/rgb stream on the same pixel-strobe domain and recovers the pixel coordinates by locking to the sync edges. Checks sync timing against 640x480@60 constants and produces a per-frame pixel checksum plus a single-pixel probe. Sits beside the display top as an on-chip self-check and as the bench's golden decoder.

## Interface

- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, pixels from end of active area to hsync leading edge
- H_SYNC, 96, hsync width
- H_BACK, 48, back porch; H_TOTAL = 800
- V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33; V_TOTAL = 525
- SYNC_POL, 1, asserted level of hsync/vsync

- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe, one clk wide, every 4th clk
- hsync, vsync  in  1  sync inputs, sampled only when pix_en=1
- rgb  in  12  pixel data, sampled only when pix_en=1
- probe_x, probe_y  in  10  coordinate to capture
- x, y  out  10  coordinate of the pixel expected at the next pix_en
- de  out  1  locked and (x,y) inside the active area
- locked  out  1  timing lock
- err_cnt  out  8  saturating count of lock losses
- frame_sum  out  32  wrap-around sum of active rgb over the last good frame
- frame_done  out  1  one-clk pulse when frame_sum updates
- probe_rgb  out  12  last captured probe pixel
- probe_valid  out  1  one-clk pulse on capture

## Operation

- Internal counters cx, cy give the pixel currently on the inputs. Both advance only on pix_en. cx wraps 799->0; cy increments on that wrap and wraps 524->0.
- Edge detect: register the previous hsync/vsync on pix_en. A leading edge is sync at SYNC_POL while the previous value was not.
- Expected edges:
  - hsync leading edge at cx = H_DISPLAY+H_FRONT = 656.
  - vsync leading edge at cx = 0, cy = V_DISPLAY+V_FRONT = 490.
- Mismatch: an edge at an unexpected position, or a missing edge at the expected position.
- FSM:
  - SEARCH: counters are free. On a vsync leading edge, load cx=0, cy=490 for that sample, then advance. Go to TRAIN.
  - TRAIN: run the edge checks. Any mismatch: go to SEARCH. An expected vsync edge at (0,490): go to LOCKED and set locked=1.
  - LOCKED: any mismatch clears locked, increments err_cnt (saturating at 255), goes to SEARCH, and clears frame_ok.
- Checksum:
  - In LOCKED, when cx<640 and cy<480, add zero-extended rgb to acc (mod 2^32).
  - At the cy 524->0 wrap in LOCKED: if frame_ok, frame_sum<=acc and pulse frame_done. Then acc<=0 and frame_ok<=1.
  - frame_ok is set only at that wrap, so the first frame after lock is never reported.
- Probe: in LOCKED, when cx==probe_x, cy==probe_y, and the pixel is active, set probe_rgb<=rgb and pulse probe_valid. Out-of-range probe coordinates never fire.
- Simultaneous events: the mismatch check takes priority over the checksum/probe update in the same sample. That sample is not accumulated, and no frame_done fires.

## Timing

- All outputs are registered. Updates happen in the clk cycle following the pix_en sample, and outputs hold between strobes.
- pix_en held low: no state change.
- Lock latency: one full frame (420,000 strobes) after the first vsync leading edge.
- Loss of lock: locked falls in the clk after the offending sample.
- Reset values, applied in one clk at any point in a frame:
  - x=y=0, de=0, locked=0, err_cnt=0, frame_sum=0.
  - frame_done=0, probe_rgb=0, probe_valid=0.
  - FSM=SEARCH, acc=0, frame_ok=0.

## Structure

- vga_timing_pkg holds the H/V timing constants and SYNC_POL. It is shared with the sync generator so both ends cannot drift.
- FSM state encoding (SEARCH/TRAIN/LOCKED) is local.
- Sub-module sync_edge_det (one instance per sync line): pix_en-qualified delay register and leading-edge output.

## Test plan

- Reset, then a clean generator stream: locked=1 exactly one frame after the first vsync edge; err_cnt=0; x/y track the generator counts.
- Constant rgb 12'h0ff over two locked frames: frame_done once per frame after the first; frame_sum=32'h04AB5000.
- probe=(320,240), generator paints 12'hf99 at that pixel: probe_rgb=12'hf99, probe_valid once per frame, de=1 at capture.
- One line stretched to 801 pixels while locked: locked falls after that hsync, err_cnt=1, no frame_done that frame, relock one clean frame later.
- Reset pulsed mid-frame at (400,200): all outputs 0 the next clk; relock follows the normal latency.
- Probe=(700,100) and pix_en stalled for 1000 clks: no probe_valid, outputs frozen during the stall.
